mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported unified RAM between the instruction-fetch path and the data-access path of the pipelined core. It sits between the caches/datapath memory interface and the RAM model. It serializes accesses through a registered grant FSM, holds the RAM-side signals stable for the whole access, and reports completion to each requester through its wait line. Data accesses normally win. An optional starvation guard forces an instruction fetch after a bounded wait.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 59 +++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, completion and RAM-side signals of the instruction/data memory arbiter
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  arb_state;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_state
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-first arbiter of one RAM between fetch and data paths; ARB_STARVE_GUARD_EN enables the fetch starvation guard
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, IFETCH = 2'd1, DLOAD = 2'd2, DSTORE = 2'd3} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ramaddr_q, ramaddr_d, ramstore_q, ramstore_d;
  logic        access, req, i_pri;
  assign access = bus.ramstate == 2'd2;
  assign req = state_q == IFETCH ? bus.iREN : state_q == DLOAD ? bus.dREN : bus.dWEN;
`ifdef ARB_STARVE_GUARD_EN
  assign i_pri = bus.iREN && cnt_q >= 4'(STARVE_LIMIT);
`else
  assign i_pri = 1'b0;
`endif
  // Grant selection in IDLE, release on completion or abort, capture of the winner's address/data
  always_comb begin
    state_d    = state_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    if (state_q == IDLE) begin
      state_d    = i_pri ? IFETCH : bus.dWEN ? DSTORE : bus.dREN ? DLOAD : bus.iREN ? IFETCH : IDLE;
      ramaddr_d  = state_d == IFETCH ? bus.iaddr : state_d == IDLE ? ramaddr_q : bus.daddr;
      ramstore_d = state_d == DSTORE ? bus.dstore : ramstore_q;
    end else begin
      state_d = (access || !req) ? IDLE : state_q;
    end
    cnt_d = (!bus.iREN || (state_q == IFETCH && access)) ? 4'd0 :
            (state_q != IFETCH && cnt_q != 4'd15) ? cnt_q + 4'd1 : cnt_q;
  end
  // State, starvation counter and held RAM address/data
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ramaddr_q  <= 32'd0;
      ramstore_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
    end
  end
  assign bus.arb_state = state_q;
  assign bus.ramREN    = state_q == IFETCH || state_q == DLOAD;
  assign bus.ramWEN    = state_q == DSTORE;
  assign bus.ramaddr   = ramaddr_q;
  assign bus.ramstore  = ramstore_q;
  assign bus.iwait     = !(state_q == IFETCH && access);
  assign bus.dwait     = !((state_q == DLOAD || state_q == DSTORE) && access);
  assign bus.iload     = bus.ramload;
  assign bus.dload     = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a transaction-level model of the arbiter
module tb_mem_arbiter;
  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int          own = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_store = 0;
  int          starve = 0;
  mem_arbiter_if bus ();
  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    own = 0;
    m_addr = 0;
    m_store = 0;
    starve = 0;
  endtask
  task automatic m_check();
    bit done = own != 0 && bus.ramstate == 2'd2;
    check("arb_state", bus.arb_state, own);
    check("ramREN", bus.ramREN, own == 1 || own == 2);
    check("ramWEN", bus.ramWEN, own == 3);
    check("ramaddr", bus.ramaddr, m_addr);
    check("ramstore", bus.ramstore, m_store);
    check("iwait", bus.iwait, !(done && own == 1));
    check("dwait", bus.dwait, !(done && own >= 2));
    check("iload", bus.iload, bus.ramload);
    check("dload", bus.dload, bus.ramload);
    check("one_wait", bus.iwait | bus.dwait, 1);
  endtask
  task automatic m_step();
    bit done = own != 0 && bus.ramstate == 2'd2;
    bit req = own == 1 ? bus.iREN : own == 2 ? bus.dREN : bus.dWEN;
    int nxt = own;
    if (own == 0) begin
      if (GUARD && bus.iREN && starve >= LIMIT) nxt = 1;
      else if (bus.dWEN) nxt = 3;
      else if (bus.dREN) nxt = 2;
      else if (bus.iREN) nxt = 1;
      else nxt = 0;
      if (nxt != 0) m_addr = nxt == 1 ? bus.iaddr : bus.daddr;
      if (nxt == 3) m_store = bus.dstore;
    end else if (done || !req) begin
      nxt = 0;
    end
    if (!bus.iREN || (done && own == 1)) starve = 0;
    else if (own != 1 && starve < 15) starve++;
    own = nxt;
  endtask
  task automatic run_cycle();
    #1;
    m_check();
    m_step();
    @(negedge CLK);
  endtask
  task automatic drive(input bit i, input bit dr, input bit dw, input logic [1:0] rs);
    bus.iREN = i;
    bus.dREN = dr;
    bus.dWEN = dw;
    bus.ramstate = rs;
  endtask
  initial begin
    int seen;
    bus.iaddr = 0;
    bus.daddr = 0;
    bus.dstore = 0;
    bus.ramload = 32'h1234_5678;
    drive(0, 0, 0, 2'd0);
    @(negedge CLK);
    #1;
    check("rst_ramREN", bus.ramREN, 0);
    check("rst_ramWEN", bus.ramWEN, 0);
    check("rst_iwait", bus.iwait, 1);
    check("rst_dwait", bus.dwait, 1);
    check("rst_state", bus.arb_state, 0);
    check("rst_iload", bus.iload, 32'h1234_5678);
    m_reset();
    @(negedge CLK);
    nRST = 1'b1;
    run_cycle();
    bus.iaddr = 32'h40;
    bus.ramload = 32'h00A0_0093;
    drive(1, 0, 0, 2'd1);
    run_cycle();
    #1;
    check("if_ramREN", bus.ramREN, 1);
    check("if_ramaddr", bus.ramaddr, 32'h40);
    check("if_iwait_busy", bus.iwait, 1);
    run_cycle();
    drive(1, 0, 0, 2'd2);
    #1;
    check("if_iwait_done", bus.iwait, 0);
    check("if_iload", bus.iload, 32'h00A0_0093);
    run_cycle();
    drive(0, 0, 0, 2'd0);
    #1;
    check("if_idle", bus.arb_state, 0);
    check("if_iwait_after", bus.iwait, 1);
    run_cycle();
    bus.daddr = 32'h80;
    bus.dstore = 32'hDEAD_BEEF;
    bus.iaddr = 32'h44;
    drive(1, 1, 1, 2'd0);
    run_cycle();
    #1;
    check("st_state", bus.arb_state, 3);
    check("st_ramWEN", bus.ramWEN, 1);
    check("st_ramREN", bus.ramREN, 0);
    check("st_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    drive(1, 1, 1, 2'd2);
    run_cycle();
    drive(1, 0, 0, 2'd0);
    #1;
    check("st_turn", bus.arb_state, 0);
    run_cycle();
    #1;
    check("st_ifetch", bus.arb_state, 1);
    check("st_ifaddr", bus.ramaddr, 32'h44);
    drive(1, 0, 0, 2'd2);
    run_cycle();
    drive(0, 0, 0, 2'd0);
    run_cycle();
    bus.daddr = 32'h100;
    drive(0, 1, 0, 2'd3);
    run_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("err_ramaddr", bus.ramaddr, 32'h100);
      check("err_ramREN", bus.ramREN, 1);
      check("err_dwait", bus.dwait, 1);
      run_cycle();
    end
    drive(0, 1, 0, 2'd2);
    #1;
    check("err_dwait_done", bus.dwait, 0);
    run_cycle();
    bus.daddr = 32'h200;
    drive(0, 1, 0, 2'd1);
    run_cycle();
    drive(0, 0, 0, 2'd1);
    #1;
    check("ab_dwait", bus.dwait, 1);
    run_cycle();
    #1;
    check("ab_idle", bus.arb_state, 0);
    check("ab_dwait_after", bus.dwait, 1);
    bus.daddr = 32'h300;
    drive(0, 1, 0, 2'd1);
    run_cycle();
    nRST = 1'b0;
    #1;
    check("mr_ramREN", bus.ramREN, 0);
    check("mr_state", bus.arb_state, 0);
    check("mr_ramaddr", bus.ramaddr, 0);
    check("mr_dwait", bus.dwait, 1);
    m_reset();
    @(negedge CLK);
    drive(0, 0, 0, 2'd0);
    nRST = 1'b1;
    run_cycle();
    run_cycle();
    seen = 0;
    bus.iaddr = 32'h500;
    bus.daddr = 32'h600;
    drive(1, 1, 0, 2'd2);
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      if (bus.arb_state == 2'd1) seen++;
    end
    check("guard_ifetch_count", seen, GUARD ? 1 : 0);
    drive(1, 0, 0, 2'd2);
    run_cycle();
    run_cycle();
    drive(0, 0, 0, 2'd0);
    run_cycle();
    for (int k = 0; k < 1500; k++) begin
      bus.iREN = $urandom_range(0, 9) < 8;
      bus.dREN = $urandom_range(0, 9) < 5;
      bus.dWEN = $urandom_range(0, 9) < 2;
      bus.iaddr = $urandom;
      bus.daddr = $urandom;
      bus.dstore = $urandom;
      bus.ramload = $urandom;
      bus.ramstate = 2'($urandom_range(0, 3));
      run_cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
